alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and two-stage issue pipeline that shares one combinational 32-bit ALU among NREQ requesters. It accepts per-requester operation requests (operands plus 4-bit select) and drives the ALU inputs from a register. It captures the ALU result and zero flag into a response register and returns them to the owning requester with valid/ready backpressure. It sits between the execute-side clients (integer pipe, address generation, debug unit) and the shared ALU instance.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  bit i: requester i presents an operation
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- req_in1  in  NREQ*32  operand 1; bits [32i+31:32i] belong to requester i
- req_in2  in  NREQ*32  operand 2, packed as req_in1
- req_sel  in  NREQ*4  ALU select; legal codes 0 AND, 1 OR, 2 ADD, 6 SUB
- rsp_valid  out  NREQ  one-hot; response for requester i is pending
- rsp_ready  in  NREQ  bit i: requester i accepts its response
- rsp_result  out  32  registered ALU result
- rsp_zero  out  1  registered ALU zero flag
- rsp_illegal  out  1  select code of the response was not in {0,1,2,6}
- op_count  out  16  completed-response counter
- alu_in1, alu_in2  out  32 each  registered ALU operands
- alu_sel  out  4  registered ALU select
- alu_result  in  32  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag

## Operation
- **Stage I (issue):** iss_valid, iss_id, iss_illegal, plus alu_in1/alu_in2/alu_sel registers.
- **Stage R (response):** rsp_valid (one-hot, decoded from the stored id), rsp_result, rsp_zero, rsp_illegal.
- **R frees:** rsp_valid is 0, or rsp_valid[i] & rsp_ready[i] holds this cycle.
- **I advances:** R frees. On advance, R loads alu_result, alu_zero, iss_illegal and iss_id, and rsp_valid = iss_valid decoded.
- **I accepts:** I is empty or I advances.
- **Grant:** only when I accepts. Grant goes to the first asserted req_valid at or after the priority pointer, wrapping modulo NREQ.
  - req_ready is combinational from req_valid, the pointer and the stall condition.
  - A requester may hold req_valid low; ready is never asserted to a non-requesting bit.
- **Pointer update:** after a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- **On grant:** alu_in1/alu_in2/alu_sel load the granted requester's slice, iss_valid=1, iss_id=i.
- **I accepts with no grant:** iss_valid=0, and the ALU registers hold their last value (no toggling).
- **Illegal select:** the code is passed to the ALU unchanged (the ALU returns 0). rsp_illegal=1 on that response.
- **op_count:** increments by 1 on every response handshake and wraps 0xFFFF -> 0x0000.
- **Response back-to-back:** a requester may have a new request granted while its previous response is still in R. Responses return strictly in grant order.
- **Reset values (asynchronous on rst_n low):**
  - all valids, iss_id, alu_in1, alu_in2, alu_sel, rsp_result, rsp_zero, rsp_illegal and op_count are 0
  - the pointer is 0, so requester 0 has highest priority
  - req_ready is 0 while rst_n is low
- **Reset mid-operation:** in-flight operations are discarded and no response is produced.

## Timing
- **Latency:** handshake at edge k; ALU registers valid after edge k; rsp_valid high after edge k+1 (response visible 2 cycles after grant).
- **Throughput:** 1 operation per cycle when rsp_ready is held high.
- **Backpressure:** with R full and rsp_ready low, R holds, I holds, and req_ready is all-zero. There is no loss or duplication.
- **Response stability:** rsp_valid, rsp_result, rsp_zero and rsp_illegal are stable while rsp_valid is high and unaccepted.
- **Simultaneous events:** a response handshake and a new grant in the same cycle are both legal and required for full throughput.
- **Combinational path:** req_valid and rsp_ready each reach req_ready through logic only. No path exists from alu_result to any output other than through registers.

## Test plan
- **Reset:** rst_n=0 mid-stream then released -> all outputs 0, pointer 0; next req_valid=4'b1111 grants requester 0 first.
- **Single op:** requester 2 sends in1=0x0000_0005, in2=0x0000_0005, sel=6 -> two cycles later rsp_valid=4'b0100, rsp_result=0, rsp_zero=1, rsp_illegal=0, op_count=1.
- **Round-robin:** all four requesters assert valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,…, one response per cycle; requester 1 doing ADD 0xFFFF_FFFF+1 returns 0x0000_0000 with zero=1.
- **Backpressure:** hold rsp_ready=0 for 5 cycles with three requesters valid -> rsp_result frozen and req_ready=0 throughout; after release, the remaining ops complete in grant order with no loss.
- **Illegal select:** sel=9, in1=0xAAAA_AAAA, in2=0x5555_5555 -> rsp_result=0, rsp_zero=1, rsp_illegal=1.
- **Counter wrap:** preload via 65536 accepted responses -> op_count returns to 0x0000 on the 65536th handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and two-stage issue/response pipeline
// that shares one combinational 32-bit ALU among NREQ requesters.
module alu_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_in1,
    input  logic [NREQ*32-1:0]   req_in2,
    input  logic [NREQ*4-1:0]    req_sel,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [15:0]          op_count,
    output logic [31:0]          alu_in1,
    output logic [31:0]          alu_in2,
    output logic [3:0]           alu_sel,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Round-robin pointer: requester with highest priority next grant
    logic [PW-1:0]   r_ptr;

    // Issue stage: owner id, illegal flag and the registered ALU operands
    logic            r_issValid;
    logic [PW-1:0]   r_issId;
    logic            r_issIllegal;
    logic [31:0]     r_aluIn1;
    logic [31:0]     r_aluIn2;
    logic [3:0]      r_aluSel;

    // Response stage: stored id is decoded into the one-hot rsp_valid
    logic            r_rspValid;
    logic [PW-1:0]   r_rspId;
    logic [31:0]     r_rspResult;
    logic            r_rspZero;
    logic            r_rspIllegal;
    logic [15:0]     r_opCount;

    logic            w_rspFire;
    logic            w_rspFree;
    logic            w_issAccept;
    logic            w_grantFound;
    logic            w_grantValid;
    logic [PW-1:0]   w_grantId;
    logic [PW:0]     w_candidate;
    logic [NREQ-1:0] w_grant;
    logic [31:0]     w_grantIn1;
    logic [31:0]     w_grantIn2;
    logic [3:0]      w_grantSel;
    logic            w_grantIllegal;
    logic [PW-1:0]   w_ptrNext;

    // R frees when empty or when its owner takes the response this cycle;
    // I can take a new operation whenever it is empty or moves into R.
    assign w_rspFire    = r_rspValid & rsp_ready[r_rspId];
    assign w_rspFree    = ~r_rspValid | w_rspFire;
    assign w_issAccept  = ~r_issValid | w_rspFree;
    assign w_grantValid = rst_n & w_issAccept & w_grantFound;

    // Search for the first requesting bit at or after the pointer, wrapping
    always_comb begin
        w_grantFound = 1'b0;
        w_grantId    = '0;
        w_candidate  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_candidate = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_candidate >= (PW+1)'(NREQ)) begin
                w_candidate = w_candidate - (PW+1)'(NREQ);
            end
            if (!w_grantFound && req_valid[w_candidate[PW-1:0]]) begin
                w_grantFound = 1'b1;
                w_grantId    = w_candidate[PW-1:0];
            end
        end
    end

    // Decode the winner and select its operand slices for the ALU registers
    always_comb begin
        w_grant    = '0;
        w_grantIn1 = '0;
        w_grantIn2 = '0;
        w_grantSel = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_grant[i] = w_grantFound && (w_grantId == PW'(i));
            if (w_grant[i]) begin
                w_grantIn1 = req_in1[32*i +: 32];
                w_grantIn2 = req_in2[32*i +: 32];
                w_grantSel = req_sel[4*i +: 4];
            end
        end
    end

    // Only AND, OR, ADD and SUB are meaningful to the ALU; anything else is flagged
    always_comb begin
        case (w_grantSel)
            4'd0, 4'd1, 4'd2, 4'd6: w_grantIllegal = 1'b0;
            default:                w_grantIllegal = 1'b1;
        endcase
    end

    // The next pointer sits just past the winner so it drops to lowest priority
    always_comb begin
        if (w_grantId == PW'(NREQ - 1)) begin
            w_ptrNext = '0;
        end else begin
            w_ptrNext = w_grantId + PW'(1);
        end
    end

    // Ready is the one-hot grant, suppressed whenever the pipeline stalls or in reset
    always_comb begin
        req_ready = w_grantValid ? w_grant : '0;
    end

    // Issue stage and pointer; ALU operands hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_issValid   <= 1'b0;
            r_issId      <= '0;
            r_issIllegal <= 1'b0;
            r_aluIn1     <= '0;
            r_aluIn2     <= '0;
            r_aluSel     <= '0;
        end else if (w_issAccept) begin
            r_issValid <= w_grantFound;
            if (w_grantFound) begin
                r_ptr        <= w_ptrNext;
                r_issId      <= w_grantId;
                r_issIllegal <= w_grantIllegal;
                r_aluIn1     <= w_grantIn1;
                r_aluIn2     <= w_grantIn2;
                r_aluSel     <= w_grantSel;
            end
        end
    end

    // Response stage captures the ALU output when the issue stage moves forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspValid   <= 1'b0;
            r_rspId      <= '0;
            r_rspResult  <= '0;
            r_rspZero    <= 1'b0;
            r_rspIllegal <= 1'b0;
        end else if (w_rspFree) begin
            r_rspValid <= r_issValid;
            if (r_issValid) begin
                r_rspId      <= r_issId;
                r_rspResult  <= alu_result;
                r_rspZero    <= alu_zero;
                r_rspIllegal <= r_issIllegal;
            end
        end
    end

    // Completed-response counter, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opCount <= '0;
        end else if (w_rspFire) begin
            r_opCount <= r_opCount + 16'd1;
        end
    end

    // One-hot response valid decoded from the stored owner id
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_rspValid && (r_rspId == PW'(i));
        end
    end

    assign rsp_result  = r_rspResult;
    assign rsp_zero    = r_rspZero;
    assign rsp_illegal = r_rspIllegal;
    assign op_count    = r_opCount;
    assign alu_in1     = r_aluIn1;
    assign alu_in2     = r_aluIn2;
    assign alu_sel     = r_aluSel;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors and hand-written sequences for alu_arbiter
// with a small ALU attached to the shared operand registers.
module tb_alu_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_in1;
    logic [127:0] req_in2;
    logic [15:0]  req_sel;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_result;
    logic         rsp_zero;
    logic         rsp_illegal;
    logic [15:0]  op_count;
    logic [31:0]  alu_in1;
    logic [31:0]  alu_in2;
    logic [3:0]   alu_sel;
    logic [31:0]  alu_result;
    logic         alu_zero;

    int checkCount = 0;
    int passCount  = 0;
    int expCount   = 0;

    typedef struct {
        int          id;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  sel;
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] rrResult[4];
    logic        rrZero[4];

    alu_arbiter #(.NREQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
        .req_sel     (req_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .op_count    (op_count),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU: AND, OR, ADD, SUB; other codes return 0
    always_comb begin
        case (alu_sel)
            4'd0:    alu_result = alu_in1 & alu_in2;
            4'd1:    alu_result = alu_in1 | alu_in2;
            4'd2:    alu_result = alu_in1 + alu_in2;
            4'd6:    alu_result = alu_in1 - alu_in2;
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] in1, input logic [31:0] in2, input logic [3:0] sel);
        req_in1[id*32 +: 32] = in1;
        req_in2[id*32 +: 32] = in2;
        req_sel[id*4 +: 4]   = sel;
    endtask

    initial begin
        vecs[0] = '{2, 32'h0000_0005, 32'h0000_0005, 4'd6, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd2, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0, 32'h00F0_00F0, 1'b0, 1'b0};
        vecs[3] = '{3, 32'h1234_0000, 32'h0000_5678, 4'd1, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{2, 32'hAAAA_AAAA, 32'h5555_5555, 4'd9, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{1, 32'h0000_0003, 32'h0000_0005, 4'd6, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[6] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd2, 32'h8000_0000, 1'b0, 1'b0};
        vecs[7] = '{3, 32'h0000_0000, 32'h0000_0000, 4'd15, 32'h0000_0000, 1'b1, 1'b1};

        rrResult[0] = 32'h0000_0002; rrZero[0] = 1'b0;
        rrResult[1] = 32'h0000_0000; rrZero[1] = 1'b1;
        rrResult[2] = 32'h0000_0005; rrZero[2] = 1'b0;
        rrResult[3] = 32'h0000_000F; rrZero[3] = 1'b0;

        // Reset held with every requester asking: nothing may be granted
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        req_in1   = '0;
        req_in2   = '0;
        req_sel   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset op_count", 32'(op_count), 32'h0);
        checkOutput("reset alu_in1", alu_in1, 32'h0);
        checkOutput("reset alu_in2", alu_in2, 32'h0);
        checkOutput("reset alu_sel", 32'(alu_sel), 32'h0);
        checkOutput("reset rsp_result", rsp_result, 32'h0);
        checkOutput("reset rsp_zero", 32'(rsp_zero), 32'h0);
        checkOutput("reset rsp_illegal", 32'(rsp_illegal), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset first grant", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;

        // Table of single operations, each walked through the full pipeline
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].id, vecs[i].in1, vecs[i].in2, vecs[i].sel);
            req_valid = 4'b0001 << vecs[i].id;
            #1;
            checkOutput("vec req_ready", 32'(req_ready), 32'(4'b0001 << vecs[i].id));
            @(negedge clk);
            req_valid = 4'b0000;
            checkOutput("vec alu_in1", alu_in1, vecs[i].in1);
            checkOutput("vec alu_sel", 32'(alu_sel), 32'(vecs[i].sel));
            checkOutput("vec early rsp_valid", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            checkOutput("vec rsp_valid", 32'(rsp_valid), 32'(4'b0001 << vecs[i].id));
            checkOutput("vec rsp_result", rsp_result, vecs[i].result);
            checkOutput("vec rsp_zero", 32'(rsp_zero), 32'(vecs[i].zero));
            checkOutput("vec rsp_illegal", 32'(rsp_illegal), 32'(vecs[i].illegal));
            expCount++;
            @(negedge clk);
            checkOutput("vec op_count", 32'(op_count), 32'(expCount));
        end

        // Reset while an operation sits in the issue stage
        @(negedge clk);
        applyStimulus(1, 32'h0000_0003, 32'h0000_0004, 4'd2);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        expCount = 0;
        checkOutput("midreset alu_in1", alu_in1, 32'h0);
        checkOutput("midreset op_count", 32'(op_count), 32'h0);
        checkOutput("midreset req_ready", 32'(req_ready), 32'h0);
        checkOutput("midreset rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("midreset no response", 32'(rsp_valid), 32'h0);
        end

        // Round robin with all four requesters asking and responses always taken
        applyStimulus(0, 32'h0000_0001, 32'h0000_0001, 4'd2);
        applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd2);
        applyStimulus(2, 32'h0000_0009, 32'h0000_0004, 4'd6);
        applyStimulus(3, 32'h0000_000C, 32'h0000_0003, 4'd1);
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            req_valid = 4'b1111;
            #1;
            checkOutput("rr req_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
            if (n >= 2) begin
                checkOutput("rr rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((n - 2) % 4)));
                checkOutput("rr rsp_result", rsp_result, rrResult[(n - 2) % 4]);
                checkOutput("rr rsp_zero", 32'(rsp_zero), 32'(rrZero[(n - 2) % 4]));
                expCount++;
            end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        checkOutput("rr drain rsp_valid 0", 32'(rsp_valid), 32'h1);
        checkOutput("rr drain rsp_result 0", rsp_result, rrResult[0]);
        expCount++;
        @(negedge clk);
        checkOutput("rr drain rsp_valid 1", 32'(rsp_valid), 32'h2);
        checkOutput("rr drain rsp_zero 1", 32'(rsp_zero), 32'h1);
        expCount++;
        @(negedge clk);
        checkOutput("rr empty", 32'(rsp_valid), 32'h0);
        checkOutput("rr op_count", 32'(op_count), 32'(expCount));

        // Backpressure: three requesters, responses refused for five cycles
        applyStimulus(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd0);
        applyStimulus(1, 32'h0000_0010, 32'h0000_0014, 4'd6);
        applyStimulus(3, 32'h0000_0100, 32'h0000_0023, 4'd2);
        req_valid = 4'b1011;
        rsp_ready = 4'b0000;
        #1;
        checkOutput("bp first grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        checkOutput("bp second grant", 32'(req_ready), 32'h1);
        checkOutput("bp R empty", 32'(rsp_valid), 32'h0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checkOutput("bp stall req_ready", 32'(req_ready), 32'h0);
            checkOutput("bp stall rsp_valid", 32'(rsp_valid), 32'h8);
            checkOutput("bp stall rsp_result", rsp_result, 32'h0000_0123);
        end
        @(negedge clk);
        rsp_ready = 4'b1111;
        #1;
        checkOutput("bp release grant", 32'(req_ready), 32'h2);
        checkOutput("bp release rsp_valid", 32'(rsp_valid), 32'h8);
        expCount++;
        @(negedge clk);
        req_valid = 4'b0000;
        checkOutput("bp order rsp_valid 0", 32'(rsp_valid), 32'h1);
        checkOutput("bp order rsp_result 0", rsp_result, 32'h0F0F_0000);
        expCount++;
        @(negedge clk);
        checkOutput("bp order rsp_valid 1", 32'(rsp_valid), 32'h2);
        checkOutput("bp order rsp_result 1", rsp_result, 32'hFFFF_FFFC);
        expCount++;
        @(negedge clk);
        checkOutput("bp drained", 32'(rsp_valid), 32'h0);
        checkOutput("bp op_count", 32'(op_count), 32'(expCount));

        // Counter wrap: reset, then 65536 back-to-back responses
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int j = 0; j <= 65538; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 2) checkOutput("wrap start", 32'(op_count), 32'h0);
            if (j == 65537) checkOutput("wrap max", 32'(op_count), 32'h0000_FFFF);
            if (j == 65538) checkOutput("wrap to zero", 32'(op_count), 32'h0);
        end
        req_valid = 4'b0000;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
